seq_engine: RTL and testbench

Parametrised sequence generator. It produces one term of a selectable integer sequence per advance event, in WIDTH-bit arithmetic, on a single clock domain. A programmable prescaler generates a clock-enable tick, so no derived clocks exist. Overflow detection, a wrap/saturate policy, single-step control and term indexing are included. It replaces the fixed 8-bit per-sequence generators and the toggled-divider clock in the top-level sequence demo, and sits between the pin decoder and `uo_out`.

---
 rtl/seq_engine.sv | 178 +++++++++++++++++
 tb/tb_seq_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_engine.sv
// seq_engine: selectable integer sequence generator with a prescaled free-run tick,
// single-step advance, wrap/saturate overflow policy and a wrapping term index.
module seq_engine #(
   parameter int WIDTH      = 8,
   parameter int DIV_W      = 24,
   parameter int IDX_W      = 8,
   parameter int SAT_ON_OVF = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step,
   input  logic             clear,
   input  logic [2:0]       mode,
   input  logic [DIV_W-1:0] div,
   output logic [WIDTH-1:0] value,
   output logic [IDX_W-1:0] index,
   output logic             valid,
   output logic             ovf,
   output logic             halted
);
   localparam int SW  = WIDTH + 2;
   localparam int PW  = 2 * WIDTH;
   localparam bit SAT = (SAT_ON_OVF != 32'sd0);

   logic [2:0]       mode_q,   mode_d;
   logic [WIDTH-1:0] value_q,  value_d;
   logic [WIDTH-1:0] nx_q,     nx_d;
   logic [WIDTH-1:0] nx2_q,    nx2_d;
   logic             nx_ovf_q, nx_ovf_d;
   logic             nx2_ovf_q, nx2_ovf_d;
   logic [WIDTH-1:0] n_q,      n_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic             valid_q,  valid_d;
   logic             ovf_q,    ovf_d;
   logic             halted_q, halted_d;
   logic [DIV_W-1:0] cnt_q,    cnt_d;

   logic             restart_s, tick_s, adv_s;
   logic [11:0]      seed_s;
   logic [SW-1:0]    sum_s;
   logic [PW-1:0]    prod_s;
   logic [WIDTH-1:0] nx2m1_s, term_s;
   logic             carry_s;

   // Seeds {index0, index1, index2} for each sequence; all fit in four bits.
   function automatic logic [11:0] seed_f(input logic [2:0] m);
      logic [11:0] s;
      case (m)
         3'd0:    s = {4'd0, 4'd1, 4'd4};
         3'd1:    s = {4'd1, 4'd3, 4'd9};
         3'd2:    s = {4'd0, 4'd1, 4'd3};
         3'd3:    s = {4'd1, 4'd1, 4'd2};
         3'd4:    s = {4'd0, 4'd1, 4'd2};
         3'd5:    s = {4'd2, 4'd1, 4'd3};
         3'd6:    s = {4'd1, 4'd1, 4'd1};
         3'd7:    s = {4'd2, 4'd3, 4'd7};
         default: s = {4'd0, 4'd1, 4'd4};
      endcase
      return s;
   endfunction

   assign restart_s = clear | (mode != mode_q);
   // A shrinking div never leaves the count stranded above it.
   assign tick_s    = (cnt_q >= div);
   assign adv_s     = ~restart_s & ~halted_q & ((run & tick_s) | (step & ~run));
   assign seed_s    = seed_f(mode);

   // Term three places ahead of value, with its true carry beyond WIDTH bits
   always_comb begin
      sum_s   = {SW{1'b0}};
      nx2m1_s = nx2_q - WIDTH'(1'b1);
      prod_s  = PW'(nx2_q) * PW'(nx2m1_s) + PW'(1'b1);
      case (mode_q)
         3'd0:    sum_s = {2'b00, nx2_q} + {1'b0, n_q, 1'b0} + SW'(1'b1);
         3'd1:    sum_s = {2'b00, nx2_q} + {1'b0, nx2_q, 1'b0};
         3'd2:    sum_s = {2'b00, nx2_q} + {2'b00, n_q} + SW'(1'b1);
         3'd3:    sum_s = {2'b00, nx2_q} + {2'b00, nx_q};
         3'd4:    sum_s = {1'b0, nx2_q, 1'b0} + {2'b00, nx_q};
         3'd5:    sum_s = {2'b00, nx2_q} + {2'b00, nx_q};
         3'd6:    sum_s = {2'b00, nx_q} + {2'b00, value_q};
         default: sum_s = {SW{1'b0}};
      endcase
      if (mode_q == 3'd7) begin
         term_s  = prod_s[WIDTH-1:0];
         carry_s = |prod_s[PW-1:WIDTH];
      end else begin
         term_s  = sum_s[WIDTH-1:0];
         carry_s = |sum_s[SW-1:WIDTH];
      end
   end

   // Next state: restart, advance (or saturating halt), prescaler
   always_comb begin
      mode_d    = mode_q;
      value_d   = value_q;
      nx_d      = nx_q;
      nx2_d     = nx2_q;
      nx_ovf_d  = nx_ovf_q;
      nx2_ovf_d = nx2_ovf_q;
      n_d       = n_q;
      idx_d     = idx_q;
      valid_d   = 1'b0;
      ovf_d     = ovf_q;
      halted_d  = halted_q;
      if (restart_s || !run) begin
         cnt_d = {DIV_W{1'b0}};
      end else if (tick_s) begin
         cnt_d = {DIV_W{1'b0}};
      end else begin
         cnt_d = cnt_q + DIV_W'(1'b1);
      end
      if (restart_s) begin
         mode_d    = mode;
         value_d   = WIDTH'(seed_s[11:8]);
         nx_d      = WIDTH'(seed_s[7:4]);
         nx2_d     = WIDTH'(seed_s[3:0]);
         nx_ovf_d  = 1'b0;
         nx2_ovf_d = 1'b0;
         n_d       = WIDTH'(2'd2);
         idx_d     = {IDX_W{1'b0}};
         ovf_d     = 1'b0;
         halted_d  = 1'b0;
      end else if (adv_s && nx_ovf_q && SAT) begin
         ovf_d    = 1'b1;
         halted_d = 1'b1;
      end else if (adv_s) begin
         value_d   = nx_q;
         nx_d      = nx2_q;
         nx2_d     = term_s;
         nx_ovf_d  = nx2_ovf_q;
         nx2_ovf_d = carry_s;
         n_d       = n_q + WIDTH'(1'b1);
         idx_d     = idx_q + IDX_W'(1'b1);
         valid_d   = 1'b1;
         ovf_d     = ovf_q | nx_ovf_q;
      end else begin
         valid_d = 1'b0;
      end
   end

   // State registers; reset leaves mode-0 history so mode 0 needs no restart
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= 3'd0;
         value_q   <= {WIDTH{1'b0}};
         nx_q      <= WIDTH'(1'b1);
         nx2_q     <= WIDTH'(3'd4);
         nx_ovf_q  <= 1'b0;
         nx2_ovf_q <= 1'b0;
         n_q       <= WIDTH'(2'd2);
         idx_q     <= {IDX_W{1'b0}};
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         halted_q  <= 1'b0;
         cnt_q     <= {DIV_W{1'b0}};
      end else begin
         mode_q    <= mode_d;
         value_q   <= value_d;
         nx_q      <= nx_d;
         nx2_q     <= nx2_d;
         nx_ovf_q  <= nx_ovf_d;
         nx2_ovf_q <= nx2_ovf_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         halted_q  <= halted_d;
         cnt_q     <= cnt_d;
      end
   end

   assign value  = value_q;
   assign index  = idx_q;
   assign valid  = valid_q;
   assign ovf    = ovf_q;
   assign halted = halted_q;
endmodule

// File: tb/tb_seq_engine.sv
// Bench for seq_engine: three instances (8-bit wrap, 8-bit saturate, 16-bit with
// 4-bit index) checked against a whole-sequence reference built from true values.
module tb_seq_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, run, step, clear;
   logic [2:0]  mode;
   logic [23:0] div;
   logic [7:0]  a_val, a_idx, s_val, s_idx;
   logic [15:0] w_val;
   logic [3:0]  w_idx;
   logic        a_vld, a_ovf, a_hlt, s_vld, s_ovf, s_hlt, w_vld, w_ovf, w_hlt;

   int n_cmp = 0;
   int n_err = 0;
   longint em[64];
   int efirst;

   seq_engine #(.WIDTH(8), .DIV_W(24), .IDX_W(8), .SAT_ON_OVF(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear(clear), .mode(mode), .div(div),
      .value(a_val), .index(a_idx), .valid(a_vld), .ovf(a_ovf), .halted(a_hlt));
   seq_engine #(.WIDTH(8), .DIV_W(24), .IDX_W(8), .SAT_ON_OVF(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear(clear), .mode(mode), .div(div),
      .value(s_val), .index(s_idx), .valid(s_vld), .ovf(s_ovf), .halted(s_hlt));
   seq_engine #(.WIDTH(16), .DIV_W(24), .IDX_W(4), .SAT_ON_OVF(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear(clear), .mode(mode), .div(div),
      .value(w_val), .index(w_idx), .valid(w_vld), .ovf(w_ovf), .halted(w_hlt));

   // Reference: terms 0..63 reduced mod 2^w, and the first index whose true value exceeds 2^w-1
   task automatic build(input int md, input int w);
      longint tt[64];
      longint mask, cap, x;
      mask   = (longint'(1) << w) - 1;
      cap    = longint'(1) << 40;
      efirst = 1000;
      for (int i = 0; i < 64; i++) begin
         case (md)
            0: begin tt[i] = longint'(i) * i; em[i] = tt[i] & mask; end
            1: if (i == 0) begin tt[i] = 1; em[i] = 1; end
               else begin tt[i] = 3 * tt[i-1]; em[i] = (3 * em[i-1]) & mask; end
            2: begin tt[i] = longint'(i) * (i + 1) / 2; em[i] = tt[i] & mask; end
            3, 5: if (i < 2) begin tt[i] = (md == 5 && i == 0) ? 2 : 1; em[i] = tt[i]; end
               else begin tt[i] = tt[i-1] + tt[i-2]; em[i] = (em[i-1] + em[i-2]) & mask; end
            4: if (i < 2) begin tt[i] = i; em[i] = i; end
               else begin tt[i] = 2 * tt[i-1] + tt[i-2]; em[i] = (2 * em[i-1] + em[i-2]) & mask; end
            6: if (i < 3) begin tt[i] = 1; em[i] = 1; end
               else begin tt[i] = tt[i-2] + tt[i-3]; em[i] = (em[i-2] + em[i-3]) & mask; end
            default: if (i == 0) begin tt[i] = 2; em[i] = 2; end
               else begin
                  x = (tt[i-1] > (longint'(1) << 20)) ? (longint'(1) << 20) : tt[i-1];
                  tt[i] = x * (x - 1) + 1;
                  em[i] = (em[i-1] * (em[i-1] - 1) + 1) & mask;
               end
         endcase
         if (tt[i] > cap) tt[i] = cap;
         if (tt[i] > mask && efirst == 1000) efirst = i;
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic restart_to(input int m);
      mode = 3'(m); clear = 1'b1; run = 1'b0; step = 1'b0;
      clk1();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] got;
      rst_n = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0; mode = 3'd0; div = 24'd0;
      repeat (2) @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
         got = {a_val, a_idx, a_vld, a_ovf, a_hlt, s_val, s_idx, s_vld, s_ovf, s_hlt,
                w_val, w_idx, w_vld, w_ovf, w_hlt};
         n_cmp++;
         if (got !== 64'd0) begin
            n_err++; $display("FAIL reset[%0d] outputs got %h want 0", r, got);
         end
         if (r == 0) begin
            @(negedge clk); rst_n = 1'b1; clk1();
         end
      end
   endtask

   task automatic test_fib_wrap();
      logic [63:0] got, exp;
      int kk;
      build(3, 8); restart_to(3); div = 24'd0; run = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         clk1();
         got = {a_val, a_idx, a_vld, a_ovf};
         exp = {em[k][7:0], 8'(k), 1'b1, (k >= efirst)};
         n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL fib_wrap k=%0d got %h want %h", k, got, exp); end
         kk  = (k < efirst) ? k : efirst - 1;
         got = {s_val, s_idx, s_vld, s_ovf, s_hlt};
         exp = {em[kk][7:0], 8'(kk), (k < efirst), (k >= efirst), (k >= efirst)};
         n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL fib_sat k=%0d got %h want %h", k, got, exp); end
      end
      run = 1'b0;
   endtask

   task automatic test_pow3_sat();
      logic [63:0] got, exp;
      int kk;
      build(1, 8); restart_to(1);
      for (int k = 1; k <= 7; k++) begin
         step = 1'b1; clk1(); step = 1'b0;
         kk  = (k < efirst) ? k : efirst - 1;
         got = {s_val, s_idx, s_vld, s_ovf, s_hlt};
         exp = {em[kk][7:0], 8'(kk), (k < efirst), (k >= efirst), (k >= efirst)};
         n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL pow3_sat k=%0d got %h want %h", k, got, exp); end
         got = {a_val, a_idx, a_vld, a_ovf, a_hlt};
         exp = {em[k][7:0], 8'(k), 1'b1, (k >= efirst), 1'b0};
         n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL pow3_wrap k=%0d got %h want %h", k, got, exp); end
         repeat ($urandom_range(0, 2)) clk1();
      end
      restart_to(1);
      got = {s_val, s_idx, s_vld, s_ovf, s_hlt};
      n_cmp++;
      if (got !== {8'd1, 8'd0, 3'b000}) begin
         n_err++; $display("FAIL pow3_clear got %h want %h", got, {8'd1, 8'd0, 3'b000});
      end
   endtask

   task automatic test_prescaler(input int d, input bit poke_step);
      logic [63:0] got, exp;
      build(2, 8); restart_to(2); div = 24'(d); run = 1'b1;
      for (int j = 1; j <= 3 * (d + 1); j++) begin
         step = poke_step ? 1'($urandom_range(0, 1)) : 1'b0;
         clk1();
         got = {a_val, a_idx, a_vld};
         exp = {em[j / (d + 1)][7:0], 8'(j / (d + 1)), (j % (d + 1) == 0)};
         n_cmp++;
         if (got !== exp) begin
            n_err++; $display("FAIL prescaler div=%0d cyc=%0d got %h want %h", d, j, got, exp);
         end
      end
      step = 1'b0; run = 1'b0;
   endtask

   task automatic test_mode_switch();
      logic [63:0] got, exp;
      build(7, 8); restart_to(7); div = 24'd0; run = 1'b1;
      repeat (3) clk1();
      n_cmp++;
      if ({a_val, a_idx} !== {em[3][7:0], 8'd3}) begin
         n_err++; $display("FAIL switch_pre got %h want %h", {a_val, a_idx}, {em[3][7:0], 8'd3});
      end
      build(0, 8); mode = 3'd0;
      for (int k = 0; k <= 3; k++) begin
         clk1();
         got = {a_val, a_idx, a_vld};
         exp = {em[k][7:0], 8'(k), (k != 0)};
         n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL switch k=%0d got %h want %h", k, got, exp); end
      end
      run = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [63:0] got, exp;
      build(4, 8); restart_to(4); div = 24'd0; run = 1'b1;
      repeat (4) clk1();
      n_cmp++;
      if ({a_val, a_idx} !== {em[4][7:0], 8'd4}) begin
         n_err++; $display("FAIL pell_pre got %h want %h", {a_val, a_idx}, {em[4][7:0], 8'd4});
      end
      rst_n = 1'b0;
      #1;
      got = {a_val, a_idx, a_vld, a_ovf, a_hlt, s_val, s_idx, s_vld, s_ovf, s_hlt,
             w_val, w_idx, w_vld, w_ovf, w_hlt};
      n_cmp++;
      if (got !== 64'd0) begin n_err++; $display("FAIL async_reset got %h want 0", got); end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         clk1();
         got = {a_val, a_idx, a_vld};
         exp = {em[k][7:0], 8'(k), (k != 0)};
         n_cmp++;
         if (got !== exp) begin n_err++; $display("FAIL pell_resume k=%0d got %h want %h", k, got, exp); end
      end
      run = 1'b0;
   endtask

   task automatic test_steps(input int md, input int n, input string tag);
      logic [63:0] got, exp_a, exp_s, exp_w;
      int kk;
      build(md, 8);
      kk    = (n < efirst) ? n : efirst - 1;
      exp_a = {em[n][7:0], 8'(n), (n >= efirst), 1'b0};
      exp_s = {em[kk][7:0], 8'(kk), (n >= efirst), (n >= efirst)};
      build(md, 16);
      exp_w = {em[n][15:0], 4'(n), (n >= efirst)};
      restart_to(md);
      for (int s = 0; s < n; s++) begin
         step = 1'b1; clk1(); step = 1'b0;
         repeat ($urandom_range(0, 2)) clk1();
      end
      got = {a_val, a_idx, a_ovf, a_hlt};
      n_cmp++;
      if (got !== exp_a) begin n_err++; $display("FAIL %s_wrap8 md=%0d n=%0d got %h want %h", tag, md, n, got, exp_a); end
      got = {s_val, s_idx, s_ovf, s_hlt};
      n_cmp++;
      if (got !== exp_s) begin n_err++; $display("FAIL %s_sat8 md=%0d n=%0d got %h want %h", tag, md, n, got, exp_s); end
      got = {w_val, w_idx, w_ovf};
      n_cmp++;
      if (got !== exp_w) begin n_err++; $display("FAIL %s_w16 md=%0d n=%0d got %h want %h", tag, md, n, got, exp_w); end
   endtask

   initial begin
      test_reset();
      test_fib_wrap();
      test_pow3_sat();
      test_prescaler(4, 1'b1);
      test_prescaler($urandom_range(1, 6), 1'b0);
      test_mode_switch();
      test_async_reset();
      test_steps(0, 17, "idx_wrap");
      for (int t = 0; t < 12; t++) begin
         test_steps($urandom_range(0, 7), $urandom_range(0, 20), "random");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
